// File: rtl/fp32_square_pipe.sv
// fp32_square_pipe: three-stage IEEE-754 binary32 squarer (out = in*in).
// Round-to-nearest-even, DAZ on input, FTZ on output, positive-only results.
// Valid/ready handshake with a single global stall; an opaque tag rides along.
module fp32_square_pipe #(
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             out_nan
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned SIG_W  = MAN_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int unsigned EB_W   = 10;
    localparam int unsigned EF_W   = EB_W + 1;

    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } cls_t;

    logic en;

    // Stage 1 registers
    logic               s1_valid;
    cls_t               s1_cls;
    logic [EXP_W-1:0]   s1_exp;
    logic [SIG_W-1:0]   s1_sig;
    logic [TAG_W-1:0]   s1_tag;

    // Stage 2 registers
    logic               s2_valid;
    cls_t               s2_cls;
    logic [PROD_W-1:0]  s2_prod;
    logic signed [EB_W-1:0] s2_eb;
    logic [TAG_W-1:0]   s2_tag;

    // Combinational helpers
    logic [EXP_W-1:0]   in_exp;
    logic [MAN_W-1:0]   in_man;
    cls_t               in_cls;
    logic               unused_sign;
    logic [PROD_W-1:0]  prod;
    logic               hi;
    logic [MAN_W-1:0]   frac_raw;
    logic               guard;
    logic               sticky;
    logic               rnd_up;
    logic [SIG_W-1:0]   frac_sum;
    logic signed [EF_W-1:0] exp_fin;
    logic [31:0]        res;
    logic               f_ovf;
    logic               f_unf;
    logic               f_nan;

    // Global stall: everything advances only when the output slot can move
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // The result is always positive, so the operand sign is never consulted
    assign unused_sign = in[31];
    assign in_exp      = in[30:23];
    assign in_man      = in[22:0];

    // Operand classification; denormals collapse to zero
    always_comb begin
        in_cls = CLS_NORM;
        if (in_exp == '0) begin
            in_cls = CLS_ZERO;
        end else if (in_exp == '1) begin
            in_cls = (in_man != '0) ? CLS_NAN : CLS_INF;
        end
    end

    // S1: capture classified operand and tag
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cls   <= CLS_ZERO;
            s1_exp   <= '0;
            s1_sig   <= '0;
            s1_tag   <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_cls   <= in_cls;
            s1_exp   <= in_exp;
            s1_sig   <= {1'b1, in_man};
            s1_tag   <= in_tag;
        end
    end

    assign prod = PROD_W'(s1_sig) * PROD_W'(s1_sig);

    // S2: mantissa product and unnormalised biased exponent 2E-127
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_cls   <= CLS_ZERO;
            s2_prod  <= '0;
            s2_eb    <= '0;
            s2_tag   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_cls   <= s1_cls;
            s2_prod  <= prod;
            s2_eb    <= $signed({1'b0, s1_exp, 1'b0} - EB_W'(127));
            s2_tag   <= s1_tag;
        end
    end

    // Normalise by at most one position, then round to nearest even
    always_comb begin
        hi       = s2_prod[PROD_W-1];
        frac_raw = hi ? s2_prod[46:24] : s2_prod[45:23];
        guard    = hi ? s2_prod[23]    : s2_prod[22];
        sticky   = hi ? (|s2_prod[22:0]) : (|s2_prod[21:0]);
        rnd_up   = guard && (sticky || frac_raw[0]);
        frac_sum = {1'b0, frac_raw} + SIG_W'(rnd_up);
        // A rounding carry leaves frac_sum[22:0] at zero and bumps the exponent
        exp_fin  = {s2_eb[EB_W-1], s2_eb} + EF_W'(hi) + EF_W'(frac_sum[SIG_W-1]);
    end

    // Special-case selection and exponent range clamp
    always_comb begin
        res   = POS_ZERO;
        f_ovf = 1'b0;
        f_unf = 1'b0;
        f_nan = 1'b0;
        case (s2_cls)
            CLS_ZERO: res = POS_ZERO;
            CLS_INF:  res = POS_INF;
            CLS_NAN: begin
                res   = QNAN;
                f_nan = 1'b1;
            end
            CLS_NORM: begin
                if (exp_fin >= EF_W'(255)) begin
                    res   = POS_INF;
                    f_ovf = 1'b1;
                end else if (exp_fin <= EF_W'(0)) begin
                    res   = POS_ZERO;
                    f_unf = 1'b1;
                end else begin
                    res = {1'b0, exp_fin[EXP_W-1:0], frac_sum[MAN_W-1:0]};
                end
            end
            default: res = POS_ZERO;
        endcase
    end

    // S3: output register; flags only asserted alongside a valid result
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_tag   <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            out_nan   <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid;
            out       <= res;
            out_tag   <= s2_tag;
            out_ovf   <= s2_valid && f_ovf;
            out_unf   <= s2_valid && f_unf;
            out_nan   <= s2_valid && f_nan;
        end
    end

endmodule

// File: tb/tb_fp32_square_pipe.sv
// Scoreboard bench for fp32_square_pipe: the driver pushes hand-computed
// expectations at acceptance, a negedge monitor checks every presented result.
module tb_fp32_square_pipe;

    localparam int unsigned TAG_W   = 8;
    localparam int unsigned NUM_VEC = 22;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out;
    logic [TAG_W-1:0] out_tag;
    logic             out_ovf;
    logic             out_unf;
    logic             out_nan;

    typedef struct packed {
        logic [31:0]      val;
        logic [TAG_W-1:0] tag;
        logic [2:0]       flg;   // {ovf, unf, nan}
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Directed vectors: operand, expected square, expected {ovf,unf,nan}
    logic [31:0] vin [NUM_VEC] = '{
        32'hBFC00000, 32'h80000000, 32'h3F800000, 32'h3F800001,
        32'h3FB504F3, 32'h3F800800, 32'h3F800801, 32'h3FFFFFFF,
        32'h60000000, 32'h1F800000, 32'h00000001, 32'h7F800001,
        32'hFFC12345, 32'hFF800000, 32'h5F000000, 32'h20000000,
        32'h7F7FFFFF, 32'h5F800000, 32'h00800000, 32'h7F800000,
        32'hBF800000, 32'h807FFFFF};
    // fl(sqrt2)^2 lies 0.574 ulp below 2.0, so it rounds to 0x3FFFFFFF
    logic [31:0] vout [NUM_VEC] = '{
        32'h40100000, 32'h00000000, 32'h3F800000, 32'h3F800002,
        32'h3FFFFFFF, 32'h3F801000, 32'h3F801003, 32'h407FFFFE,
        32'h7F800000, 32'h00000000, 32'h00000000, 32'h7FC00000,
        32'h7FC00000, 32'h7F800000, 32'h7E800000, 32'h00800000,
        32'h7F800000, 32'h7F800000, 32'h00000000, 32'h7F800000,
        32'h3F800000, 32'h00000000};
    logic [2:0] vflg [NUM_VEC] = '{
        3'b000, 3'b000, 3'b000, 3'b000,
        3'b000, 3'b000, 3'b000, 3'b000,
        3'b100, 3'b010, 3'b000, 3'b001,
        3'b001, 3'b000, 3'b000, 3'b000,
        3'b100, 3'b100, 3'b010, 3'b000,
        3'b000, 3'b000};

    fp32_square_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_tag   (out_tag),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_nan   (out_nan)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one operand until accepted, recording its expectation at acceptance
    task automatic send(input logic [31:0] d, input logic [TAG_W-1:0] t,
                        input logic [31:0] e, input logic [2:0] f);
        int   n  = 0;
        exp_t ex;
        in_valid = 1'b1;
        in       = d;
        in_tag   = t;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: tag 0x%02h not accepted, in_ready=%0b expected 1", t, in_ready);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        ex.val = e;
        ex.tag = t;
        ex.flg = f;
        q.push_back(ex);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented result with the queue head; pop on handshake
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got tag 0x%02h out 0x%08h, expected no result", out_tag, out);
            end else begin
                mon_e = q[0];
                check($sformatf("out[tag %02h]", mon_e.tag), out, mon_e.val);
                check($sformatf("out_tag[tag %02h]", mon_e.tag), 32'(out_tag), 32'(mon_e.tag));
                check($sformatf("flags[tag %02h]", mon_e.tag),
                      32'({out_ovf, out_unf, out_nan}), 32'(mon_e.flg));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in        = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(1'b0));
        check("rst_out", out, 32'h0);
        check("rst_out_tag", 32'(out_tag), 32'h0);
        check("rst_flags", 32'({out_ovf, out_unf, out_nan}), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'(1'b1));
        @(posedge clk);
        #1;

        // Latency: 3.0 squared, result appears exactly three cycles after acceptance
        send(32'h40400000, 8'h11, 32'h41100000, 3'b000);
        @(negedge clk);
        check("lat_cycle1_valid", 32'(out_valid), 32'(1'b0));
        @(posedge clk);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(out_valid), 32'(1'b0));
        @(posedge clk);
        @(negedge clk);
        check("lat_cycle3_valid", 32'(out_valid), 32'(1'b1));
        @(posedge clk);
        #1;
        drain();

        // Arithmetic, rounding, range limits and specials, back-to-back
        for (int i = 0; i < int'(NUM_VEC); i++) begin
            send(vin[i], TAG_W'(8'h40 + i), vout[i], vflg[i]);
        end
        drain();

        // Backpressure: 8 operands streaming, consumer stalls for 4 cycles
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(32'h3F800000 + (32'(i) << 23), TAG_W'(i),
                         32'h3F800000 + (32'(2 * i) << 23), 3'b000);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("stall_in_ready", 32'(in_ready), 32'(1'b0));
                    check("stall_out_valid", 32'(out_valid), 32'(1'b1));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operands in flight: none of them may ever appear
        out_ready = 1'b0;
        send(32'h40400000, 8'h20, 32'h41100000, 3'b000);
        send(32'h40400000, 8'h21, 32'h41100000, 3'b000);
        send(32'h40400000, 8'h22, 32'h41100000, 3'b000);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'(1'b0));
        check("midrst_in_ready", 32'(in_ready), 32'(1'b1));
        check("midrst_out_tag", 32'(out_tag), 32'h0);
        @(posedge clk);
        #1;
        send(32'h40000000, 8'h30, 32'h40800000, 3'b000);
        send(32'h3F000000, 8'h31, 32'h3E800000, 3'b000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
